// File: rtl/entropy_bit_packer.sv
// entropy_bit_packer
// Packs right-aligned variable-length codewords (0..32 bits) into an MSB-first
// stream of 32-bit words. A flush pads the stream to a word boundary and marks
// the final word of the slice. When a flush lands on a cycle that also
// completes a full word, the remainder is emitted one cycle later from FLUSH2.
module entropy_bit_packer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [31:0] in_sum,
    input  logic [5:0]  in_len,
    input  logic        flush,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_word,
    output logic [2:0]  out_bytes,
    output logic        out_last,
    output logic [31:0] bit_count
);

    typedef enum logic {
        RUN    = 1'b0,
        FLUSH2 = 1'b1
    } state_t;

    state_t      state, state_nxt;

    logic [63:0] acc, acc_nxt;
    logic [5:0]  fill, fill_nxt;
    logic [31:0] bit_count_nxt;
    logic        out_valid_nxt;
    logic        out_last_nxt;
    logic [31:0] out_word_nxt;
    logic [2:0]  out_bytes_nxt;

    logic [5:0]  eff_len;
    logic        append;
    logic [63:0] len_mask;
    logic [63:0] masked_val;
    logic [6:0]  shamt;
    logic [63:0] acc_app;
    logic [6:0]  fill_sum;
    logic [6:0]  fill_over;
    logic        full;
    logic [63:0] acc_rem;
    logic [5:0]  fill_rem;
    logic [5:0]  last_fill;
    logic [6:0]  bytes_round;
    logic [2:0]  last_bytes;

    // Inputs are only honoured outside FLUSH2, which is the single bubble.
    assign in_ready = (state == RUN);

    // Append datapath: clamp the length, mask the codeword, place it just
    // below the bits already held, and split off a completed word if any.
    always_comb begin
        eff_len     = (in_len > 6'd32) ? 6'd32 : in_len;
        append      = (state == RUN) && in_valid && (eff_len != 6'd0);
        len_mask    = (64'd1 << eff_len) - 64'd1;
        masked_val  = {32'd0, in_sum} & len_mask;
        shamt       = 7'd64 - {1'b0, fill} - {1'b0, eff_len};
        acc_app     = append ? (acc | (masked_val << shamt)) : acc;
        fill_sum    = {1'b0, fill} + (append ? {1'b0, eff_len} : 7'd0);
        fill_over   = fill_sum - 7'd32;
        full        = (fill_sum >= 7'd32);
        acc_rem     = full ? {acc_app[31:0], 32'd0} : acc_app;
        fill_rem    = full ? fill_over[5:0] : fill_sum[5:0];
        last_fill   = (state == FLUSH2) ? fill : fill_rem;
        bytes_round = {1'b0, last_fill} + 7'd7;
        last_bytes  = bytes_round[5:3];
    end

    // Next-state and output decode for the RUN / FLUSH2 sequencing.
    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        fill_nxt      = fill;
        bit_count_nxt = bit_count;
        out_valid_nxt = 1'b0;
        out_last_nxt  = 1'b0;
        out_word_nxt  = out_word;
        out_bytes_nxt = out_bytes;

        case (state)
            RUN: begin
                acc_nxt  = acc_rem;
                fill_nxt = fill_rem;
                if (append) begin
                    bit_count_nxt = bit_count + {26'd0, eff_len};
                end
                if (full) begin
                    out_valid_nxt = 1'b1;
                    out_word_nxt  = acc_app[63:32];
                    out_bytes_nxt = 3'd4;
                end
                if (flush) begin
                    if (full) begin
                        state_nxt = FLUSH2;
                    end else begin
                        out_valid_nxt = 1'b1;
                        out_last_nxt  = 1'b1;
                        out_word_nxt  = acc_rem[63:32];
                        out_bytes_nxt = last_bytes;
                        acc_nxt       = 64'd0;
                        fill_nxt      = 6'd0;
                        bit_count_nxt = 32'd0;
                    end
                end
            end
            FLUSH2: begin
                out_valid_nxt = 1'b1;
                out_last_nxt  = 1'b1;
                out_word_nxt  = acc[63:32];
                out_bytes_nxt = last_bytes;
                acc_nxt       = 64'd0;
                fill_nxt      = 6'd0;
                bit_count_nxt = 32'd0;
                state_nxt     = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // State, accumulator, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RUN;
            acc       <= 64'd0;
            fill      <= 6'd0;
            bit_count <= 32'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_word  <= 32'd0;
            out_bytes <= 3'd0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            fill      <= fill_nxt;
            bit_count <= bit_count_nxt;
            out_valid <= out_valid_nxt;
            out_last  <= out_last_nxt;
            out_word  <= out_word_nxt;
            out_bytes <= out_bytes_nxt;
        end
    end

endmodule

// File: tb/tb_entropy_bit_packer.sv
// Directed testbench for entropy_bit_packer with hand-computed expectations.
module tb_entropy_bit_packer;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] in_sum;
    logic [5:0]  in_len;
    logic        flush;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_word;
    logic [2:0]  out_bytes;
    logic        out_last;
    logic [31:0] bit_count;

    int total;
    int bad;

    entropy_bit_packer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_sum    (in_sum),
        .in_len    (in_len),
        .flush     (flush),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_word  (out_word),
        .out_bytes (out_bytes),
        .out_last  (out_last),
        .bit_count (bit_count)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] s, input logic [5:0] l, input logic f);
        in_valid = v;
        in_sum   = s;
        in_len   = l;
        flush    = f;
    endtask

    task automatic test_reset();
        drive(1'b0, 32'd0, 6'd0, 1'b0);
        reset_n = 1'b0;
        #2;
        total++;
        if ({out_valid, out_last, out_bytes, out_word} !== {1'b0, 1'b0, 3'd0, 32'd0}) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got v=%0b l=%0b b=%0d w=%h want v=0 l=0 b=0 w=00000000",
                     out_valid, out_last, out_bytes, out_word);
        end
        total++;
        if ({in_ready, bit_count} !== {1'b1, 32'd0}) begin
            bad++;
            $display("[TB] FAIL reset_ready_count: got rdy=%0b bc=%0d want rdy=1 bc=0", in_ready, bit_count);
        end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_word_of_ones();
        drive(1'b1, 32'h5, 6'd3, 1'b0);
        tick();
        for (int i = 0; i < 29; i++) begin
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL ones_no_early_word: step=%0d got v=%0b want v=0", i, out_valid);
            end
            drive(1'b1, 32'h1, 6'd1, 1'b0);
            tick();
        end
        total++;
        if ({out_valid, out_last, out_bytes, out_word} !== {1'b1, 1'b0, 3'd4, 32'hBFFFFFFF}) begin
            bad++;
            $display("[TB] FAIL ones_word: got v=%0b l=%0b b=%0d w=%h want v=1 l=0 b=4 w=bfffffff",
                     out_valid, out_last, out_bytes, out_word);
        end
        total++;
        if (bit_count !== 32'd32) begin
            bad++;
            $display("[TB] FAIL ones_bit_count: got %0d want 32", bit_count);
        end
        drive(1'b0, 32'd0, 6'd0, 1'b1);
        tick();
        total++;
        if ({out_valid, out_last, out_bytes, out_word} !== {1'b1, 1'b1, 3'd0, 32'd0}) begin
            bad++;
            $display("[TB] FAIL ones_empty_last: got v=%0b l=%0b b=%0d w=%h want v=1 l=1 b=0 w=00000000",
                     out_valid, out_last, out_bytes, out_word);
        end
        total++;
        if (bit_count !== 32'd0) begin
            bad++;
            $display("[TB] FAIL ones_count_clear: got %0d want 0", bit_count);
        end
        drive(1'b0, 32'd0, 6'd0, 1'b0);
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL ones_single_strobe: got v=%0b want v=0", out_valid);
        end
    endtask

    task automatic test_masking();
        drive(1'b1, 32'hFFFFFFFF, 6'd12, 1'b0);
        tick();
        drive(1'b1, 32'h0, 6'd20, 1'b0);
        tick();
        total++;
        if ({out_valid, out_last, out_bytes, out_word} !== {1'b1, 1'b0, 3'd4, 32'hFFF00000}) begin
            bad++;
            $display("[TB] FAIL mask12_word: got v=%0b l=%0b b=%0d w=%h want v=1 l=0 b=4 w=fff00000",
                     out_valid, out_last, out_bytes, out_word);
        end
        drive(1'b0, 32'd0, 6'd0, 1'b1);
        tick();
        total++;
        if ({out_valid, out_last, out_bytes, out_word} !== {1'b1, 1'b1, 3'd0, 32'd0}) begin
            bad++;
            $display("[TB] FAIL mask12_fill_zero: got v=%0b l=%0b b=%0d w=%h want v=1 l=1 b=0 w=00000000",
                     out_valid, out_last, out_bytes, out_word);
        end
        drive(1'b1, 32'hFFFFFFFF, 6'd4, 1'b0);
        tick();
        drive(1'b1, 32'h0, 6'd0, 1'b1);
        tick();
        total++;
        if ({out_valid, out_last, out_bytes, out_word} !== {1'b1, 1'b1, 3'd1, 32'hF0000000}) begin
            bad++;
            $display("[TB] FAIL mask4_last: got v=%0b l=%0b b=%0d w=%h want v=1 l=1 b=1 w=f0000000",
                     out_valid, out_last, out_bytes, out_word);
        end
    endtask

    task automatic test_flush_with_full_word();
        drive(1'b1, 32'h12345, 6'd20, 1'b0);
        tick();
        drive(1'b1, 32'hABC, 6'd12, 1'b1);
        tick();
        total++;
        if ({out_valid, out_last, out_bytes, out_word} !== {1'b1, 1'b0, 3'd4, 32'h12345ABC}) begin
            bad++;
            $display("[TB] FAIL flush2_full_word: got v=%0b l=%0b b=%0d w=%h want v=1 l=0 b=4 w=12345abc",
                     out_valid, out_last, out_bytes, out_word);
        end
        total++;
        if ({in_ready, bit_count} !== {1'b0, 32'd32}) begin
            bad++;
            $display("[TB] FAIL flush2_ready_low: got rdy=%0b bc=%0d want rdy=0 bc=32", in_ready, bit_count);
        end
        drive(1'b1, 32'hFFFFFFFF, 6'd32, 1'b1);
        tick();
        total++;
        if ({out_valid, out_last, out_bytes, out_word} !== {1'b1, 1'b1, 3'd0, 32'd0}) begin
            bad++;
            $display("[TB] FAIL flush2_last_word: got v=%0b l=%0b b=%0d w=%h want v=1 l=1 b=0 w=00000000",
                     out_valid, out_last, out_bytes, out_word);
        end
        total++;
        if ({in_ready, bit_count} !== {1'b1, 32'd0}) begin
            bad++;
            $display("[TB] FAIL flush2_after: got rdy=%0b bc=%0d want rdy=1 bc=0", in_ready, bit_count);
        end
        drive(1'b0, 32'd0, 6'd0, 1'b0);
        tick();
        total++;
        if ({out_valid, bit_count} !== {1'b0, 32'd0}) begin
            bad++;
            $display("[TB] FAIL flush2_input_ignored: got v=%0b bc=%0d want v=0 bc=0", out_valid, bit_count);
        end
        drive(1'b0, 32'd0, 6'd0, 1'b1);
        tick();
        total++;
        if ({out_valid, out_last, out_bytes, out_word} !== {1'b1, 1'b1, 3'd0, 32'd0}) begin
            bad++;
            $display("[TB] FAIL flush2_nothing_kept: got v=%0b l=%0b b=%0d w=%h want v=1 l=1 b=0 w=00000000",
                     out_valid, out_last, out_bytes, out_word);
        end
    endtask

    task automatic test_partial_flush();
        drive(1'b1, 32'h3FF, 6'd10, 1'b0);
        tick();
        total++;
        if ({out_valid, bit_count} !== {1'b0, 32'd10}) begin
            bad++;
            $display("[TB] FAIL partial_count: got v=%0b bc=%0d want v=0 bc=10", out_valid, bit_count);
        end
        drive(1'b0, 32'd0, 6'd0, 1'b1);
        tick();
        total++;
        if ({out_valid, out_last, out_bytes, out_word} !== {1'b1, 1'b1, 3'd2, 32'hFFC00000}) begin
            bad++;
            $display("[TB] FAIL partial_last: got v=%0b l=%0b b=%0d w=%h want v=1 l=1 b=2 w=ffc00000",
                     out_valid, out_last, out_bytes, out_word);
        end
        total++;
        if (bit_count !== 32'd0) begin
            bad++;
            $display("[TB] FAIL partial_count_clear: got %0d want 0", bit_count);
        end
    endtask

    task automatic test_len_clamp();
        drive(1'b1, 32'h12345678, 6'd40, 1'b0);
        tick();
        total++;
        if ({out_valid, out_last, out_bytes, out_word} !== {1'b1, 1'b0, 3'd4, 32'h12345678}) begin
            bad++;
            $display("[TB] FAIL clamp_word: got v=%0b l=%0b b=%0d w=%h want v=1 l=0 b=4 w=12345678",
                     out_valid, out_last, out_bytes, out_word);
        end
        total++;
        if (bit_count !== 32'd32) begin
            bad++;
            $display("[TB] FAIL clamp_count: got %0d want 32", bit_count);
        end
        drive(1'b0, 32'd0, 6'd0, 1'b1);
        tick();
        total++;
        if ({out_valid, out_last, out_bytes, out_word} !== {1'b1, 1'b1, 3'd0, 32'd0}) begin
            bad++;
            $display("[TB] FAIL clamp_last: got v=%0b l=%0b b=%0d w=%h want v=1 l=1 b=0 w=00000000",
                     out_valid, out_last, out_bytes, out_word);
        end
    endtask

    task automatic test_reset_in_flush2();
        drive(1'b1, 32'hFFFFF, 6'd20, 1'b0);
        tick();
        drive(1'b1, 32'h123, 6'd12, 1'b1);
        tick();
        total++;
        if ({in_ready, out_valid, out_word} !== {1'b0, 1'b1, 32'hFFFFF123}) begin
            bad++;
            $display("[TB] FAIL rstf2_enter: got rdy=%0b v=%0b w=%h want rdy=0 v=1 w=fffff123",
                     in_ready, out_valid, out_word);
        end
        drive(1'b0, 32'd0, 6'd0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({in_ready, out_valid, out_last, out_bytes, out_word, bit_count} !==
            {1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0}) begin
            bad++;
            $display("[TB] FAIL rstf2_immediate: got rdy=%0b v=%0b l=%0b b=%0d w=%h bc=%0d want rdy=1 v=0 l=0 b=0 w=00000000 bc=0",
                     in_ready, out_valid, out_last, out_bytes, out_word, bit_count);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL rstf2_no_last: cycle=%0d got v=%0b want v=0", i, out_valid);
            end
        end
        reset_n = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rstf2_release_quiet: got v=%0b want v=0", out_valid);
        end
        drive(1'b1, 32'hDEADBEEF, 6'd32, 1'b0);
        tick();
        total++;
        if ({out_valid, out_last, out_bytes, out_word} !== {1'b1, 1'b0, 3'd4, 32'hDEADBEEF}) begin
            bad++;
            $display("[TB] FAIL rstf2_fresh_word: got v=%0b l=%0b b=%0d w=%h want v=1 l=0 b=4 w=deadbeef",
                     out_valid, out_last, out_bytes, out_word);
        end
        drive(1'b0, 32'd0, 6'd0, 1'b0);
        tick();
    endtask

    // Run every scenario in order, then report.
    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_word_of_ones();
        test_masking();
        test_flush_with_full_word();
        test_partial_flush();
        test_len_clamp();
        test_reset_in_flush2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/entropy_bit_packer.md
# entropy_bit_packer

Packs the variable-length codewords produced by the entropy coder stages (AC run, AC level, DC) into a contiguous MSB-first bitstream of 32-bit words. It sits directly downstream of the run/level codeword generators: each cycle it accepts one (value, length) pair and appends the low `length` bits of the value to an internal accumulator. Completed 32-bit words are emitted with a valid strobe. A flush request pads the stream to a word boundary and marks the last word, closing out a slice.

## Interface
- No parameters.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: codeword present this cycle.
- `in_sum` in 32: codeword bits, right-aligned. Only the low `in_len` bits are used.
- `in_len` in 6: codeword length, 0..32. 0 is a no-op. Values 33..63 are treated as 32.
- `flush` in 1: end of slice. Pad the stream and emit the final word.
- `in_ready` out 1: low only in state FLUSH2. Inputs and flush are ignored while it is low.
- `out_valid` out 1: `out_word` is valid this cycle.
- `out_word` out 32: packed bits. The first bit in the stream is bit 31.
- `out_bytes` out 3: number of meaningful bytes in `out_word`, 0..4. It is 4 for every non-last word.
- `out_last` out 1: final word of the slice. Asserted together with `out_valid`.
- `bit_count` out 32: total bits accepted since the last flush completed.

## Operation
- Storage:
  - 64-bit accumulator `acc`, left-aligned.
  - 6-bit fill count `fill`, range 0..31 between cycles.
  - Two states: RUN and FLUSH2.
- Append (RUN, `in_valid`, effective length L>0):
  - Masked value `v = in_sum & ((1<<L)-1)`.
  - `acc |= v << (64 - fill - L)`, then `fill += L`.
  - If `fill >= 32`: emit `acc[63:32]` with `out_bytes=4`, shift `acc` left by 32, and `fill -= 32`.
  - At most one word is emitted per input, because `fill + L <= 63`.
- `bit_count += L`, wrapping modulo 2^32. It increments only on accepted inputs.
- Flush in RUN, with no input or with the input already appended as above:
  - No full word pending this cycle: emit `acc[63:32]` (unused bits zero) with `out_last=1` and `out_bytes = ceil(fill/8)`. Then clear `acc`, `fill` and `bit_count`.
  - If `fill` is 0, this still emits one beat: `out_word=0`, `out_bytes=0`, `out_last=1`.
  - A full word was emitted this cycle: emit that full word, then go to FLUSH2 with the remainder.
- FLUSH2:
  - `in_ready=0`.
  - Next cycle emit the remainder as the last word, using the same rules as above (ceil, `out_last`, clears).
  - Return to RUN.
- `in_valid` with L=0 changes nothing. `flush` is still honoured in that cycle.
- Reset values (asynchronous, immediate):
  - State RUN.
  - `acc=0`, `fill=0`.
  - `out_valid=0`, `out_word=0`, `out_bytes=0`, `out_last=0`.
  - `bit_count=0`, `in_ready=1`.
- Reset while in FLUSH2 discards the remainder. No last beat is produced.

## Timing
- All outputs are registered.
- A word completed by an input sampled at edge N is visible during cycle N+1, with `out_valid` high for exactly one cycle.
- Flush at edge N:
  - Last word visible at N+1.
  - If a full word also completed at N, the full word is visible at N+1 and the last word at N+2. `in_ready` is low during N+1.
- `bit_count` reflects inputs sampled up to the previous edge. Its clear takes effect on the edge that emits the last beat.
- No backpressure on the output side. The consumer must accept one word per cycle.
- The sustained rate is one codeword per cycle, except the single FLUSH2 bubble.

## Test plan
- Codeword (0x5,3), then 29× (0x1,1), then flush:
  - First beat: `out_word=0xBFFFFFFF`, `out_bytes=4`.
  - Next cycle: `out_word=0`, `out_bytes=0`, `out_last=1`.
  - `bit_count` is 32 before the clear.
- Codeword (0xFFFFFFFF,12), then (0x0,20):
  - Emits `0xFFF00000`, `out_bytes=4`, `fill` returns to 0.
  - Upper-bit masking test: `in_sum=0xFFFFFFFF` with `in_len=4` contributes only 0xF.
- 20 bits buffered, then (0xABC,12) with flush in the same cycle:
  - Full word at N+1, `in_ready=0` in that cycle.
  - Last word at N+2 with `out_bytes=0` and `out_last=1`.
  - Inputs presented during FLUSH2 are ignored.
- 10 bits 0x3FF, then flush:
  - `out_word=0xFFC00000`, `out_bytes=2`, `out_last=1`, `bit_count` clears to 0.
- `in_len=40` with `in_sum=0x12345678`: treated as 32, emits `0x12345678`.
- Assert `reset_n=0` during FLUSH2:
  - All outputs go to reset values immediately and no last beat follows.
  - After release, a fresh 32-bit codeword emits unchanged.
